// File: rtl/awg_sweep_ctrl.sv
// awg_sweep_ctrl: stepped-frequency sweep sequencer for one phase-accumulator
// waveform generator. Latches a sweep configuration on start, steps the tuning
// word from f_start towards f_stop with a programmable dwell per step, and
// repeats the sweep cfg_repeat times (0 = until abort).
// Optional feature macro: AWG_PING_PONG_EN (alternate up/down legs instead of
// sawtooth reload; each leg counts as one sweep).
module awg_sweep_ctrl #(
    parameter int FREQ_W  = 12,
    parameter int DWELL_W = 16,
    parameter int AMP_W   = 3,
    parameter int PHASE_W = 8,
    parameter int REP_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [FREQ_W-1:0]  cfg_f_start,
    input  logic [FREQ_W-1:0]  cfg_f_stop,
    input  logic [FREQ_W-1:0]  cfg_f_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [AMP_W-1:0]   cfg_amp,
    input  logic [PHASE_W-1:0] cfg_phase,
    input  logic [REP_W-1:0]   cfg_repeat,
    output logic               gen_en,
    output logic [FREQ_W-1:0]  gen_freq,
    output logic [AMP_W-1:0]   gen_amp,
    output logic [PHASE_W-1:0] gen_phase,
    output logic               busy,
    output logic               done,
    output logic [REP_W-1:0]   sweep_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t state, state_nxt;

    // Shadow copies of the run configuration; cfg_* may change freely mid-run.
    logic [FREQ_W-1:0]  sh_f_start, sh_f_stop, sh_f_step;
    logic [DWELL_W-1:0] sh_dwell;
    logic [REP_W-1:0]   sh_repeat;
    logic [DWELL_W-1:0] dwell_cnt;

    logic [DWELL_W-1:0] dwell_max;
    logic [FREQ_W:0]    up_sum;
    logic               up_ok;
    logic               adv_ok;
    logic [FREQ_W-1:0]  adv_freq;
    logic               term;
    logic               sweep_end;
    logic               last_sweep;
    logic [REP_W-1:0]   cnt_inc;

`ifdef AWG_PING_PONG_EN
    logic               dir_down;
    logic [FREQ_W:0]    dn_dif;
    logic               dn_ok;
`endif

    // Step arithmetic: one extra bit catches carry (up) or borrow (down).
    always_comb begin
        dwell_max = (sh_dwell == '0) ? DWELL_W'(1) : sh_dwell;
        term      = (dwell_cnt >= dwell_max);
        up_sum    = {1'b0, gen_freq} + {1'b0, sh_f_step};
        up_ok     = !up_sum[FREQ_W] && (up_sum[FREQ_W-1:0] <= sh_f_stop);
`ifdef AWG_PING_PONG_EN
        dn_dif    = {1'b0, gen_freq} - {1'b0, sh_f_step};
        dn_ok     = !dn_dif[FREQ_W] && (dn_dif[FREQ_W-1:0] >= sh_f_start);
        adv_ok    = dir_down ? dn_ok : up_ok;
        adv_freq  = dir_down ? dn_dif[FREQ_W-1:0] : up_sum[FREQ_W-1:0];
`else
        adv_ok    = up_ok;
        adv_freq  = up_sum[FREQ_W-1:0];
`endif
        cnt_inc    = sweep_cnt + REP_W'(1);
        // A zero step never leaves f_start, so the sweep never ends.
        sweep_end  = term && (sh_f_step != '0) && !adv_ok;
        last_sweep = sweep_end && (sh_repeat != '0) && (cnt_inc == sh_repeat);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; abort overrides everything.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) state_nxt = S_RUN;
                S_RUN:   if (last_sweep) state_nxt = S_DONE;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Registered outputs, shadow config and dwell/step datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gen_en     <= 1'b0;
            gen_freq   <= '0;
            gen_amp    <= AMP_W'(1);
            gen_phase  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sweep_cnt  <= '0;
            dwell_cnt  <= '0;
            sh_f_start <= '0;
            sh_f_stop  <= '0;
            sh_f_step  <= '0;
            sh_dwell   <= '0;
            sh_repeat  <= '0;
`ifdef AWG_PING_PONG_EN
            dir_down   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (abort) begin
                // gen_freq and sweep_cnt deliberately keep their last values.
                gen_en <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: if (start) begin
                        sh_f_start <= cfg_f_start;
                        sh_f_stop  <= cfg_f_stop;
                        sh_f_step  <= cfg_f_step;
                        sh_dwell   <= cfg_dwell;
                        sh_repeat  <= cfg_repeat;
                        gen_freq   <= cfg_f_start;
                        gen_amp    <= (cfg_amp == '0) ? AMP_W'(1) : cfg_amp;
                        gen_phase  <= cfg_phase;
                        gen_en     <= 1'b1;
                        busy       <= 1'b1;
                        sweep_cnt  <= '0;
                        dwell_cnt  <= DWELL_W'(1);
`ifdef AWG_PING_PONG_EN
                        dir_down   <= 1'b0;
`endif
                    end
                    S_RUN: begin
                        if (!term) begin
                            dwell_cnt <= dwell_cnt + DWELL_W'(1);
                        end else begin
                            dwell_cnt <= DWELL_W'(1);
                            if (sh_f_step == '0) begin
                                // hold f_start forever
                            end else if (adv_ok) begin
                                gen_freq <= adv_freq;
                            end else begin
                                sweep_cnt <= cnt_inc;
                                if (last_sweep) begin
                                    gen_en <= 1'b0;
                                    done   <= 1'b1;
                                end else begin
`ifdef AWG_PING_PONG_EN
                                    // Turn around; if the first step of the new
                                    // leg is out of range, hold for one dwell.
                                    dir_down <= !dir_down;
                                    if (dir_down)
                                        gen_freq <= up_ok ? up_sum[FREQ_W-1:0] : gen_freq;
                                    else
                                        gen_freq <= dn_ok ? dn_dif[FREQ_W-1:0] : gen_freq;
`else
                                    gen_freq <= sh_f_start;
`endif
                                end
                            end
                        end
                    end
                    S_DONE: busy <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

endmodule
